// File: rtl/decoder_result_arbiter.sv
// Round-robin merge of add/cancel decoder results into one registered valid/ready stream.
// Optional grant statistics are enabled with the ARB_STATS_EN macro.
module decoder_result_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add_internal_valid,
  input  logic             add_packet_invalid,
  input  logic [63:0]      add_order_ref,
  input  logic             add_side,
  input  logic [31:0]      add_shares,
  input  logic [31:0]      add_price,
  input  logic [63:0]      add_stock_symbol,
  input  logic             cancel_internal_valid,
  input  logic             cancel_packet_invalid,
  input  logic [63:0]      cancel_order_ref,
  input  logic [31:0]      cancel_canceled_shares,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_msg_type,
  output logic [63:0]      out_order_ref,
  output logic             out_side,
  output logic [31:0]      out_shares,
  output logic [31:0]      out_price,
  output logic [63:0]      out_stock_symbol,
  output logic [CNT_W-1:0] add_drop_cnt,
  output logic [CNT_W-1:0] cancel_drop_cnt
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] add_grant_cnt,
  output logic [CNT_W-1:0] cancel_grant_cnt
`endif
);

  typedef enum logic {SRC_ADD = 1'b0, SRC_CANCEL = 1'b1} src_e;

  localparam logic [7:0] TYPE_ADD    = 8'h41;
  localparam logic [7:0] TYPE_CANCEL = 8'h58;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  src_e rr_last_q, rr_last_d;
  logic add_pend_q, add_pend_d, cancel_pend_q, cancel_pend_d;
  logic [63:0] add_ref_q, add_sym_q, cancel_ref_q;
  logic [31:0] add_shares_q, add_price_q, cancel_shares_q;
  logic        add_side_q;

  logic        out_valid_q, out_valid_d, out_side_q, out_side_d;
  logic [7:0]  out_type_q, out_type_d;
  logic [63:0] out_ref_q, out_ref_d, out_sym_q, out_sym_d;
  logic [31:0] out_shares_q, out_shares_d, out_price_q, out_price_d;
  logic [CNT_W-1:0] add_drop_q, add_drop_d, cancel_drop_q, cancel_drop_d;

  logic out_free, grant_add, grant_cancel;
  logic add_cap, cancel_cap, add_load, cancel_load;

  // Output handshake: a beat transfers on a cycle with out_valid=1 and out_ready=1;
  // while out_valid=1 and out_ready=0 every out_* field is held.
  always_comb begin
    out_free     = !out_valid_q || out_ready;
    grant_add    = out_free && add_pend_q && (!cancel_pend_q || rr_last_q == SRC_CANCEL);
    grant_cancel = out_free && cancel_pend_q && !grant_add;
    add_cap      = add_internal_valid && !add_packet_invalid;
    cancel_cap   = cancel_internal_valid && !cancel_packet_invalid;
    add_load     = add_cap && (!add_pend_q || grant_add);
    cancel_load  = cancel_cap && (!cancel_pend_q || grant_cancel);
    add_pend_d    = (add_pend_q && !grant_add) || add_cap;
    cancel_pend_d = (cancel_pend_q && !grant_cancel) || cancel_cap;

    add_drop_d    = add_drop_q;
    cancel_drop_d = cancel_drop_q;
    if (add_cap && !add_load && add_drop_q != CNT_MAX)
      add_drop_d = add_drop_q + CNT_W'(1);
    if (cancel_cap && !cancel_load && cancel_drop_q != CNT_MAX)
      cancel_drop_d = cancel_drop_q + CNT_W'(1);

    rr_last_d    = rr_last_q;
    out_valid_d  = out_valid_q;
    out_type_d   = out_type_q;
    out_ref_d    = out_ref_q;
    out_side_d   = out_side_q;
    out_shares_d = out_shares_q;
    out_price_d  = out_price_q;
    out_sym_d    = out_sym_q;
    if (grant_add) begin
      rr_last_d    = SRC_ADD;
      out_valid_d  = 1'b1;
      out_type_d   = TYPE_ADD;
      out_ref_d    = add_ref_q;
      out_side_d   = add_side_q;
      out_shares_d = add_shares_q;
      out_price_d  = add_price_q;
      out_sym_d    = add_sym_q;
    end else if (grant_cancel) begin
      rr_last_d    = SRC_CANCEL;
      out_valid_d  = 1'b1;
      out_type_d   = TYPE_CANCEL;
      out_ref_d    = cancel_ref_q;
      out_side_d   = 1'b0;
      out_shares_d = cancel_shares_q;
      out_price_d  = 32'd0;
      out_sym_d    = 64'd0;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q     <= SRC_CANCEL;
      add_pend_q    <= 1'b0;
      cancel_pend_q <= 1'b0;
      add_drop_q    <= '0;
      cancel_drop_q <= '0;
      out_valid_q   <= 1'b0;
      out_type_q    <= '0;
      out_ref_q     <= '0;
      out_side_q    <= 1'b0;
      out_shares_q  <= '0;
      out_price_q   <= '0;
      out_sym_q     <= '0;
    end else begin
      rr_last_q     <= rr_last_d;
      add_pend_q    <= add_pend_d;
      cancel_pend_q <= cancel_pend_d;
      add_drop_q    <= add_drop_d;
      cancel_drop_q <= cancel_drop_d;
      out_valid_q   <= out_valid_d;
      out_type_q    <= out_type_d;
      out_ref_q     <= out_ref_d;
      out_side_q    <= out_side_d;
      out_shares_q  <= out_shares_d;
      out_price_q   <= out_price_d;
      out_sym_q     <= out_sym_d;
    end
  end

  // Pending payloads are only meaningful while their flag is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (add_load) begin
      add_ref_q    <= add_order_ref;
      add_side_q   <= add_side;
      add_shares_q <= add_shares;
      add_price_q  <= add_price;
      add_sym_q    <= add_stock_symbol;
    end
    if (cancel_load) begin
      cancel_ref_q    <= cancel_order_ref;
      cancel_shares_q <= cancel_canceled_shares;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_msg_type     = out_type_q;
  assign out_order_ref    = out_ref_q;
  assign out_side         = out_side_q;
  assign out_shares       = out_shares_q;
  assign out_price        = out_price_q;
  assign out_stock_symbol = out_sym_q;
  assign add_drop_cnt     = add_drop_q;
  assign cancel_drop_cnt  = cancel_drop_q;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] add_grant_q, cancel_grant_q;
  logic             hs;
  assign hs = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      add_grant_q    <= '0;
      cancel_grant_q <= '0;
    end else begin
      if (hs && out_type_q == TYPE_ADD && add_grant_q != CNT_MAX)
        add_grant_q <= add_grant_q + CNT_W'(1);
      if (hs && out_type_q == TYPE_CANCEL && cancel_grant_q != CNT_MAX)
        cancel_grant_q <= cancel_grant_q + CNT_W'(1);
    end
  end

  assign add_grant_cnt    = add_grant_q;
  assign cancel_grant_cnt = cancel_grant_q;
`endif

endmodule

// File: tb/tb_decoder_result_arbiter.sv
// Directed bench for decoder_result_arbiter: per-cycle reference model plus literal checkpoints.
module tb_decoder_result_arbiter;
  localparam int CNT_W = 3;

  logic clk, rst;
  logic add_internal_valid, add_packet_invalid, add_side;
  logic [63:0] add_order_ref, add_stock_symbol, cancel_order_ref;
  logic [31:0] add_shares, add_price, cancel_canceled_shares;
  logic cancel_internal_valid, cancel_packet_invalid;
  logic out_valid, out_ready, out_side;
  logic [7:0] out_msg_type;
  logic [63:0] out_order_ref, out_stock_symbol;
  logic [31:0] out_shares, out_price;
  logic [CNT_W-1:0] add_drop_cnt, cancel_drop_cnt;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] add_grant_cnt, cancel_grant_cnt;
`endif

  decoder_result_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .add_internal_valid(add_internal_valid), .add_packet_invalid(add_packet_invalid),
    .add_order_ref(add_order_ref), .add_side(add_side), .add_shares(add_shares),
    .add_price(add_price), .add_stock_symbol(add_stock_symbol),
    .cancel_internal_valid(cancel_internal_valid), .cancel_packet_invalid(cancel_packet_invalid),
    .cancel_order_ref(cancel_order_ref), .cancel_canceled_shares(cancel_canceled_shares),
    .out_valid(out_valid), .out_ready(out_ready), .out_msg_type(out_msg_type),
    .out_order_ref(out_order_ref), .out_side(out_side), .out_shares(out_shares),
    .out_price(out_price), .out_stock_symbol(out_stock_symbol),
    .add_drop_cnt(add_drop_cnt), .cancel_drop_cnt(cancel_drop_cnt)
`ifdef ARB_STATS_EN
    , .add_grant_cnt(add_grant_cnt), .cancel_grant_cnt(cancel_grant_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0]  t;
    logic [63:0] oref;
    logic        side;
    logic [31:0] shares;
    logic [31:0] price;
    logic [63:0] sym;
  } msg_t;

  int checks = 0;
  int errors = 0;

  // Reference model: each source holds at most one waiting message, one output slot.
  msg_t             m_pend[2];
  logic             m_pv[2];
  msg_t             m_out;
  logic             m_ov;
  int               m_rr;
  logic [CNT_W-1:0] m_drop[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pv[0] = 1'b0; m_pv[1] = 1'b0;
    m_ov = 1'b0; m_out = '0; m_rr = 1;
    m_drop[0] = '0; m_drop[1] = '0;
  endtask

  task automatic model_offer(input int s, input msg_t m);
    if (!m_pv[s]) begin
      m_pend[s] = m;
      m_pv[s] = 1'b1;
    end else if (m_drop[s] != {CNT_W{1'b1}}) begin
      m_drop[s] = m_drop[s] + 1'b1;
    end
  endtask

  task automatic model_step();
    int g;
    logic free;
    free = !m_ov || out_ready;
    if (m_ov && out_ready) m_ov = 1'b0;
    g = -1;
    if (free) begin
      if (m_pv[0] && m_pv[1]) g = (m_rr == 1) ? 0 : 1;
      else if (m_pv[0]) g = 0;
      else if (m_pv[1]) g = 1;
    end
    if (g >= 0) begin
      m_out = m_pend[g]; m_ov = 1'b1; m_pv[g] = 1'b0; m_rr = g;
    end
    if (add_internal_valid && !add_packet_invalid)
      model_offer(0, '{8'h41, add_order_ref, add_side, add_shares, add_price, add_stock_symbol});
    if (cancel_internal_valid && !cancel_packet_invalid)
      model_offer(1, '{8'h58, cancel_order_ref, 1'b0, cancel_canceled_shares, 32'd0, 64'd0});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("model out_valid", {63'd0, out_valid}, {63'd0, m_ov});
      if (m_ov) begin
        chk("model msg_type", {56'd0, out_msg_type}, {56'd0, m_out.t});
        chk("model order_ref", out_order_ref, m_out.oref);
        chk("model side", {63'd0, out_side}, {63'd0, m_out.side});
        chk("model shares", {32'd0, out_shares}, {32'd0, m_out.shares});
        chk("model price", {32'd0, out_price}, {32'd0, m_out.price});
        chk("model symbol", out_stock_symbol, m_out.sym);
      end
      chk("model add_drop", 64'(add_drop_cnt), 64'(m_drop[0]));
      chk("model cancel_drop", 64'(cancel_drop_cnt), 64'(m_drop[1]));
    end
  end

  task automatic set_add(input logic [63:0] r, input logic [31:0] sh, input logic [31:0] pr);
    add_internal_valid = 1'b1; add_packet_invalid = 1'b0;
    add_order_ref = r; add_side = 1'b1; add_shares = sh; add_price = pr;
    add_stock_symbol = 64'h4150504C20202020;
  endtask

  task automatic set_cancel(input logic [63:0] r, input logic [31:0] sh, input logic inv);
    cancel_internal_valid = 1'b1; cancel_packet_invalid = inv;
    cancel_order_ref = r; cancel_canceled_shares = sh;
  endtask

  task automatic step();
    @(negedge clk);
    add_internal_valid = 1'b0; add_packet_invalid = 1'b0;
    cancel_internal_valid = 1'b0; cancel_packet_invalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; out_ready = 1'b1;
    add_internal_valid = 0; add_packet_invalid = 0; add_order_ref = 0; add_side = 0;
    add_shares = 0; add_price = 0; add_stock_symbol = 0;
    cancel_internal_valid = 0; cancel_packet_invalid = 0; cancel_order_ref = 0;
    cancel_canceled_shares = 0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset msg_type", 64'(out_msg_type), 64'd0);
    chk("reset order_ref", out_order_ref, 64'd0);
    chk("reset add_drop", 64'(add_drop_cnt), 64'd0);

    // single add: visible two edges after the pulse, for one beat
    set_add(64'h1122334455667788, 32'd100, 32'h0001E240);
    step();
    chk("single latency1 valid", 64'(out_valid), 64'd0);
    step();
    chk("single valid", 64'(out_valid), 64'd1);
    chk("single type", 64'(out_msg_type), 64'h41);
    chk("single ref", out_order_ref, 64'h1122334455667788);
    chk("single shares", 64'(out_shares), 64'd100);
    chk("single price", 64'(out_price), 64'h0001E240);
    step();
    chk("single one beat", 64'(out_valid), 64'd0);

    // simultaneous pulses after reset, twice
    do_reset();
    for (int k = 0; k < 2; k++) begin
      set_add(64'hA0 + 64'(k), 32'd5, 32'd7);
      set_cancel(64'hC0 + 64'(k), 32'd9, 1'b0);
      step(); step();
      chk("simul first type", 64'(out_msg_type), 64'h41);
      chk("simul first ref", out_order_ref, 64'hA0 + 64'(k));
      step();
      chk("simul second type", 64'(out_msg_type), 64'h58);
      chk("simul second ref", out_order_ref, 64'hC0 + 64'(k));
      chk("simul cancel shares", 64'(out_shares), 64'd9);
      chk("simul cancel price", 64'(out_price), 64'd0);
      chk("simul cancel symbol", out_stock_symbol, 64'd0);
      step();
      chk("simul drained", 64'(out_valid), 64'd0);
    end

    // backpressure overflow
    out_ready = 1'b0;
    set_add(64'hB1, 32'd1, 32'd1); step(); step();
    set_add(64'hB2, 32'd2, 32'd2); step(); step();
    set_add(64'hB3, 32'd3, 32'd3); step();
    chk("overflow drop", 64'(add_drop_cnt), 64'd1);
    chk("overflow head ref", out_order_ref, 64'hB1);
    out_ready = 1'b1;
    step();
    chk("overflow second ref", out_order_ref, 64'hB2);
    step();
    chk("overflow drained", 64'(out_valid), 64'd0);

    // rejected cancel is neither delivered nor counted
    set_cancel(64'hDEAD, 32'd4, 1'b1);
    repeat (4) step();
    chk("invalid no output", 64'(out_valid), 64'd0);
    chk("invalid no drop", 64'(cancel_drop_cnt), 64'd0);

    // hold under stall while cancels arrive
    out_ready = 1'b0;
    set_add(64'h5151, 32'd77, 32'd88); step(); step();
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) set_cancel(64'hC100 + 64'(i), 32'd11, 1'b0);
      step();
      chk("stall ref hold", out_order_ref, 64'h5151);
      chk("stall shares hold", 64'(out_shares), 64'd77);
      chk("stall type hold", 64'(out_msg_type), 64'h41);
    end
    chk("stall cancel drops", 64'(cancel_drop_cnt), 64'd4);
    out_ready = 1'b1;
    step();
    chk("stall cancel type", 64'(out_msg_type), 64'h58);
    chk("stall cancel ref", out_order_ref, 64'hC100);
    step();

    // back-to-back adds drain and refill on the same edge without loss
    for (int i = 0; i < 6; i++) begin
      if (i < 4) set_add(64'hD0 + 64'(i), 32'd3, 32'd4);
      step();
      if (i >= 1 && i <= 4) chk("refill ref", out_order_ref, 64'hD0 + 64'(i - 1));
    end
    chk("refill no drop", 64'(add_drop_cnt), 64'd1);

    // drop counter saturates
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_add(64'hE0 + 64'(i), 32'd1, 32'd2);
      step();
    end
    chk("drop saturate", 64'(add_drop_cnt), 64'd7);

    // async reset with output busy and both sources pending
    set_cancel(64'hF00D, 32'd6, 1'b0);
    step();
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async add_drop", 64'(add_drop_cnt), 64'd0);
    chk("async cancel_drop", 64'(cancel_drop_cnt), 64'd0);
    chk("async msg_type", 64'(out_msg_type), 64'd0);
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    set_add(64'hAA, 32'd1, 32'd1);
    set_cancel(64'hCC, 32'd2, 1'b0);
    step(); step();
    chk("post reset first", 64'(out_msg_type), 64'h41);
    step();
    chk("post reset second", 64'(out_msg_type), 64'h58);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decoder_result_arbiter.md
Name: decoder_result_arbiter

Overview:
Merges decoded results from add_order_decoder and cancel_order_decoder into one downstream message stream with a valid/ready handshake. Each source has a one-entry pending register. A round-robin arbiter moves one pending entry per cycle into a registered output stage. The block sits between the speculative ITCH decoders and the order-book / downstream consumer.

Parameters:
CNT_W, 16, width of the drop counters and the optional statistics counters (saturating)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (asserted at 0)
add_internal_valid  input  1  one-cycle pulse: add-order decode complete
add_packet_invalid  input  1  add decode rejected; qualifies add_internal_valid
add_order_ref  input  64  add order reference
add_side  input  1  buy/sell indicator
add_shares  input  32  share count
add_price  input  32  price
add_stock_symbol  input  64  stock symbol
cancel_internal_valid  input  1  one-cycle pulse: cancel decode complete
cancel_packet_invalid  input  1  cancel decode rejected; qualifies cancel_internal_valid
cancel_order_ref  input  64  cancel order reference
cancel_canceled_shares  input  32  canceled share count
out_valid  output  1  output message valid
out_ready  input  1  consumer accepts the message when out_valid=1 and out_ready=1
out_msg_type  output  8  ITCH type: 0x41 'A' or 0x58 'X'
out_order_ref  output  64  order reference
out_side  output  1  add only; 0 for cancel
out_shares  output  32  add_shares, or cancel_canceled_shares for cancel
out_price  output  32  add only; 0 for cancel
out_stock_symbol  output  64  add only; 0 for cancel
add_drop_cnt  output  CNT_W  saturating count of add results lost to overflow
cancel_drop_cnt  output  CNT_W  saturating count of cancel results lost to overflow

Behaviour:
- Reset (rst=0, async): pending flags clear, out_valid=0, all out_* fields 0, drop counters 0, rr_last=CANCEL so ADD wins first. Pending data registers are don't-care.
- Capture: a valid pulse with packet_invalid=0 loads that source's pending register at the edge. A valid pulse with packet_invalid=1 is ignored and is not counted as a drop.
- Out stage free: out_valid=0, or out_valid=1 with out_ready=1 in the same cycle.
- Arbitration (combinational on pending flags, only when the out stage is free):
  - Only one source pending: grant that source.
  - Both pending: grant the source other than rr_last.
  - On each grant: update rr_last to the granted source; load out_* from that pending entry; clear its pending flag.
- Latency: valid pulse in cycle N → pending set after edge N → out_valid=1 in cycle N+2 if the out stage is free. This minimum latency is 2 cycles and is fixed; there is no bypass.
- Same-edge drain and refill: if a source is granted and a new valid pulse arrives for it on the same edge, the pending flag stays 1 and holds the new data. No drop.
- Overflow: a valid pulse arrives while the source's pending flag=1 and that source is not granted on that edge. The new result is discarded, the old entry is kept, and that source's drop counter increments, saturating at all-ones.
- Output stability: while out_valid=1 and out_ready=0, all out_* fields hold constant.
- Throughput: at most one message per cycle. With out_ready held at 1, sustained 1 msg/cycle alternating sources.
- Reset mid-transfer: all pending and in-flight messages are lost; out_valid drops asynchronously.

Optional Feature:
ARB_STATS_EN
- Defined: adds outputs add_grant_cnt and cancel_grant_cnt (CNT_W each, saturating). Each increments on an out_valid & out_ready handshake whose out_msg_type matches. Both reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single add: add_internal_valid pulse with order_ref=0x1122334455667788, shares=100, price=0x0001E240, out_ready=1 → exactly 2 cycles later out_valid=1, out_msg_type=0x41, fields match, single beat.
- Simultaneous pulses: add and cancel valid in the same cycle after reset, out_ready=1 → 'A' delivered first, then 'X' the next cycle. Repeat both → 'A', 'X' again (rr alternates).
- Backpressure overflow: out_ready=0; three add pulses spaced 1 cycle apart → first sits in out stage, second in pending, third dropped (add_drop_cnt=1). Release out_ready → exactly 2 'A' messages with the first two order_refs.
- Invalid qualifier: cancel_internal_valid=1 with cancel_packet_invalid=1 → no output, cancel_drop_cnt stays 0.
- Hold under stall: out_valid=1, out_ready=0 for 10 cycles while cancel pulses arrive → out_* unchanged throughout. The cancel is delivered after out_ready rises.
- Async reset mid-stream: assert rst=0 between clock edges while out_valid=1 and both pending → out_valid=0 immediately, counters 0. After release, the first simultaneous pair grants 'A' first.
